// File: rtl/mem32_arbiter.sv
// Two-client round-robin arbiter in front of the 32-bit memory request port.
// One client is granted at a time. The chosen request is registered toward memory
// and held until memory accepts it by echoing the latched tag. The read return
// is fanned out unchanged to both clients.
module mem32_arbiter #(
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned ADDR_W = 26
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              c0_request,
    input  logic [TAG_W-1:0]  c0_tag,
    input  logic [ADDR_W-1:0] c0_address,
    input  logic              c0_direction,
    input  logic [3:0]        c0_byte_en,
    input  logic [31:0]       c0_wdata,
    output logic [TAG_W-1:0]  c0_dack_tag,
    output logic              c0_rack,
    output logic [TAG_W-1:0]  c0_rack_tag,
    output logic [31:0]       c0_rdata,

    input  logic              c1_request,
    input  logic [TAG_W-1:0]  c1_tag,
    input  logic [ADDR_W-1:0] c1_address,
    input  logic              c1_direction,
    input  logic [3:0]        c1_byte_en,
    input  logic [31:0]       c1_wdata,
    output logic [TAG_W-1:0]  c1_dack_tag,
    output logic              c1_rack,
    output logic [TAG_W-1:0]  c1_rack_tag,
    output logic [31:0]       c1_rdata,

    output logic              mem32_request,
    output logic [TAG_W-1:0]  mem32_tag,
    output logic [ADDR_W-1:0] mem32_address,
    output logic              mem32_direction,
    output logic [3:0]        mem32_byte_en,
    output logic [31:0]       mem32_wdata,
    input  logic [TAG_W-1:0]  mem32_dack_tag,
    input  logic              mem32_rack,
    input  logic [TAG_W-1:0]  mem32_rack_tag,
    input  logic [31:0]       mem32_rdata
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              req_q, req_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              pick;
    logic              accept;

    // Memory accepts only when it echoes the latched tag; other tags are ignored.
    assign accept = (state_q == StBusy) && req_q && (mem32_dack_tag == tag_q);

    // Next-state: grant in idle (round-robin on a tie), wait for the matching accept in busy.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        req_d        = req_q;
        tag_d        = tag_q;
        addr_d       = addr_q;
        dir_d        = dir_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        // On a tie the client that did not win last time goes next.
        pick         = (c0_request && c1_request) ? ~last_grant_q : c1_request;

        unique case (state_q)
            StIdle: begin
                if (c0_request || c1_request) begin
                    state_d      = StBusy;
                    last_grant_d = pick;
                    grant_d      = pick;
                    req_d        = 1'b1;
                    tag_d        = pick ? c1_tag       : c0_tag;
                    addr_d       = pick ? c1_address   : c0_address;
                    dir_d        = pick ? c1_direction : c0_direction;
                    be_d         = pick ? c1_byte_en   : c0_byte_en;
                    wdata_d      = pick ? c1_wdata     : c0_wdata;
                end
            end
            StBusy: begin
                if (accept) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered downstream request; reset drops the request immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            req_q        <= 1'b0;
            tag_q        <= '0;
            addr_q       <= '0;
            dir_q        <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            req_q        <= req_d;
            tag_q        <= tag_d;
            addr_q       <= addr_d;
            dir_q        <= dir_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
        end
    end

    assign mem32_request   = req_q;
    assign mem32_tag       = tag_q;
    assign mem32_address   = addr_q;
    assign mem32_direction = dir_q;
    assign mem32_byte_en   = be_q;
    assign mem32_wdata     = wdata_q;

    // Accept goes only to the granted client, in the same cycle.
    always_comb begin
        c0_dack_tag = (accept && !grant_q) ? mem32_dack_tag : '0;
        c1_dack_tag = (accept &&  grant_q) ? mem32_dack_tag : '0;
    end

    // Read return is broadcast; clients filter on their own tags.
    assign c0_rack     = mem32_rack;
    assign c0_rack_tag = mem32_rack_tag;
    assign c0_rdata    = mem32_rdata;
    assign c1_rack     = mem32_rack;
    assign c1_rack_tag = mem32_rack_tag;
    assign c1_rdata    = mem32_rdata;

endmodule
